// File: rtl/button_pulse_conditioner.sv
// Push-button front end: two-flop synchroniser, per-button tick-gated
// debounce and single-cycle press pulse with the pressed button's code.
module button_pulse_conditioner #(
    parameter int N_BTN     = 3,
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 2
) (
    input  logic             clock_in,
    input  logic             clr,
    input  logic             en_tick,
    input  logic [N_BTN-1:0] bn,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse,
    output logic             any_pulse,
    output logic [1:0]       btn_code,
    output logic             multi_press
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [N_BTN-1:0] s1_q;
    logic [N_BTN-1:0] s2_q;

    logic [CNT_W-1:0] cnt_q [N_BTN];
    logic [CNT_W-1:0] cnt_d [N_BTN];

    logic [N_BTN-1:0] db_q;
    logic [N_BTN-1:0] db_d;
    logic [N_BTN-1:0] lvl_q;

    logic [N_BTN-1:0] pulse_q;
    logic [N_BTN-1:0] pulse_d;
    logic             any_q;
    logic             any_d;
    logic [1:0]       code_q;
    logic [1:0]       code_d;
    logic             multi_q;
    logic             multi_d;

    // Two-flop synchroniser, free-running on every clock edge
    always_ff @(posedge clock_in or negedge clr) begin
        if (!clr) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= bn;
            s2_q <= s2_d_of(s1_q);
        end
    end

    function automatic logic [N_BTN-1:0] s2_d_of(input logic [N_BTN-1:0] v);
        return v;
    endfunction

    // Debounce: count ticks of disagreement, flip the level once it lasts
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (en_tick) begin
            for (int i = 0; i < N_BTN; i++) begin
                if (s2_q[i] == db_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] >= CNT_MAX) begin
                    db_d[i]  = ~db_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Debounce state registers
    always_ff @(posedge clock_in or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
            end
            db_q <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            db_q <= db_d;
        end
    end

    // Rising-edge detect on the debounced level; lowest index wins the code
    always_comb begin
        logic [N_BTN-1:0] rise;
        rise    = db_q & ~lvl_q;
        pulse_d = rise;
        any_d   = |rise;
        multi_d = |(rise & (rise - N_BTN'(1)));
        code_d  = code_q;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (rise[i]) begin
                code_d = 2'(i);
            end
        end
    end

    // Pulse, strobe and code registers; lvl_q delays the level one cycle
    always_ff @(posedge clock_in or negedge clr) begin
        if (!clr) begin
            lvl_q   <= '0;
            pulse_q <= '0;
            any_q   <= 1'b0;
            code_q  <= 2'd0;
            multi_q <= 1'b0;
        end else begin
            lvl_q   <= db_q;
            pulse_q <= pulse_d;
            any_q   <= any_d;
            code_q  <= code_d;
            multi_q <= multi_d;
        end
    end

    assign btn_level   = db_q;
    assign btn_pulse   = pulse_q;
    assign any_pulse   = any_q;
    assign btn_code    = code_q;
    assign multi_press = multi_q;

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Directed bench for button_pulse_conditioner: press, bounce, tick gating,
// simultaneous press, mid-count reset and release/re-press.
module tb_button_pulse_conditioner;

    logic       clock_in;
    logic       clr;
    logic       en_tick;
    logic [2:0] bn;
    logic [2:0] btn_level;
    logic [2:0] btn_pulse;
    logic       any_pulse;
    logic [1:0] btn_code;
    logic       multi_press;

    int checks;
    int errors;
    int npulse;
    int nany;

    button_pulse_conditioner #(
        .N_BTN    (3),
        .DB_CYCLES(4),
        .CNT_W    (2)
    ) dut (
        .clock_in   (clock_in),
        .clr        (clr),
        .en_tick    (en_tick),
        .bn         (bn),
        .btn_level  (btn_level),
        .btn_pulse  (btn_pulse),
        .any_pulse  (any_pulse),
        .btn_code   (btn_code),
        .multi_press(multi_press)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge, then settle; tallies pulse cycles seen
    task automatic tick();
        @(posedge clock_in);
        #1;
        if (btn_pulse != 3'b000) npulse++;
        if (any_pulse) nany++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic bad;
        checks  = 0;
        errors  = 0;
        npulse  = 0;
        nany    = 0;
        clr     = 1'b0;
        en_tick = 1'b1;
        bn      = 3'b000;

        // Reset state
        #12;
        chk("rst_level", {29'd0, btn_level}, 0);
        chk("rst_pulse", {29'd0, btn_pulse}, 0);
        chk("rst_any", {31'd0, any_pulse}, 0);
        chk("rst_code", {30'd0, btn_code}, 0);
        chk("rst_multi", {31'd0, multi_press}, 0);
        @(negedge clock_in);
        clr = 1'b1;
        idle(3);

        // Clean press of button 1
        npulse = 0;
        nany   = 0;
        bn     = 3'b010;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 5) chk("p1_lvl_e5", {29'd0, btn_level}, 3'b000);
            if (k == 6) chk("p1_lvl_e6", {29'd0, btn_level}, 3'b010);
            if (k == 6) chk("p1_pls_e6", {29'd0, btn_pulse}, 3'b000);
            if (k == 7) begin
                chk("p1_pls_e7", {29'd0, btn_pulse}, 3'b010);
                chk("p1_any_e7", {31'd0, any_pulse}, 1);
                chk("p1_code", {30'd0, btn_code}, 1);
                chk("p1_multi", {31'd0, multi_press}, 0);
            end
            if (k == 8) chk("p1_pls_e8", {29'd0, btn_pulse}, 3'b000);
        end
        chk("p1_npulse", npulse, 1);
        chk("p1_nany", nany, 1);

        // Release produces no pulse, code holds
        npulse = 0;
        bn     = 3'b000;
        idle(10);
        chk("rel_level", {29'd0, btn_level}, 0);
        chk("rel_npulse", npulse, 0);
        chk("rel_code", {30'd0, btn_code}, 1);

        // Bounce on button 0
        npulse = 0;
        bad    = 1'b0;
        for (int k = 0; k < 12; k++) begin
            bn = (k % 2 == 0) ? 3'b001 : 3'b000;
            tick();
            if (btn_level[0]) bad = 1'b1;
        end
        bn = 3'b000;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (btn_level[0]) bad = 1'b1;
        end
        chk("bnc_level", {31'd0, bad}, 0);
        chk("bnc_npulse", npulse, 0);
        chk("bnc_code", {30'd0, btn_code}, 1);

        // Tick gating: en_tick on edges 4,8,12,16,... after press
        npulse = 0;
        bn     = 3'b100;
        for (int k = 1; k <= 24; k++) begin
            en_tick = (k % 4 == 0);
            tick();
            if (k == 15) chk("tg_lvl_e15", {29'd0, btn_level}, 3'b000);
            if (k == 16) chk("tg_lvl_e16", {29'd0, btn_level}, 3'b100);
            if (k == 17) begin
                chk("tg_pls_e17", {29'd0, btn_pulse}, 3'b100);
                chk("tg_code", {30'd0, btn_code}, 2);
            end
        end
        chk("tg_npulse", npulse, 1);
        en_tick = 1'b1;
        bn      = 3'b000;
        idle(10);

        // Simultaneous press of buttons 1 and 2
        npulse = 0;
        bn     = 3'b110;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 7) begin
                chk("sim_pls", {29'd0, btn_pulse}, 3'b110);
                chk("sim_code", {30'd0, btn_code}, 1);
                chk("sim_multi", {31'd0, multi_press}, 1);
            end
            if (k == 8) chk("sim_multi_e8", {31'd0, multi_press}, 0);
        end
        chk("sim_npulse", npulse, 1);

        // Overlap: 1 still held (release 2 only), then press 2 again
        npulse = 0;
        bn     = 3'b010;
        idle(10);
        chk("ovl_lvl_hold", {29'd0, btn_level}, 3'b010);
        bn = 3'b110;
        idle(12);
        chk("ovl_code", {30'd0, btn_code}, 2);
        chk("ovl_lvl", {29'd0, btn_level}, 3'b110);
        chk("ovl_npulse", npulse, 1);
        bn = 3'b000;
        idle(10);

        // Reset mid-count on button 0
        npulse = 0;
        bn     = 3'b001;
        idle(4);
        clr = 1'b0;
        #1;
        chk("mr_level", {29'd0, btn_level}, 0);
        chk("mr_code", {30'd0, btn_code}, 0);
        chk("mr_pulse", {29'd0, btn_pulse}, 0);
        idle(2);
        chk("mr_any", {31'd0, any_pulse}, 0);
        clr    = 1'b1;
        npulse = 0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k == 6) chk("mr_pls_e6", {29'd0, btn_pulse}, 3'b000);
            if (k == 7) chk("mr_pls_e7", {29'd0, btn_pulse}, 3'b001);
        end
        chk("mr_code_after", {30'd0, btn_code}, 0);
        chk("mr_npulse", npulse, 1);
        bn = 3'b000;
        idle(10);

        // Release then re-press of button 1
        npulse = 0;
        bn     = 3'b010;
        idle(20);
        bn = 3'b000;
        idle(6);
        chk("rp_lvl_rel", {29'd0, btn_level}, 3'b000);
        bn = 3'b010;
        idle(20);
        chk("rp_npulse", npulse, 2);
        chk("rp_code", {30'd0, btn_code}, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
